// File: rtl/ledpanel_pkg.sv
// Shared widths, pixel count and fill-engine state type for the LED panel write path.
package ledpanel_pkg;

    localparam int unsigned X_W       = 5;
    localparam int unsigned Y_W       = 5;
    localparam int unsigned RGB_W     = 24;
    localparam int unsigned PIX_COUNT = 1024;
    localparam int unsigned CNT_W     = $clog2(PIX_COUNT);

    typedef enum logic [0:0] {
        IDLE,
        FILL
    } fill_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic with a last-grant pointer; RR_EN selects round-robin or m0-first priority.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic CLK12MHZ,
    input  logic resetn,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 means m1 was granted most recently; resets that way so m0 wins the first tie.
    logic last_q;
    logic pick0;

    always_comb begin
        pick0 = req0 & (~req1 | ~RR_EN | last_q);
        gnt0  = en & pick0;
        gnt1  = en & req1 & ~pick0;
    end

    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (gnt0) begin
            last_q <= 1'b0;
        end else if (gnt1) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ledpanel_wr_arb.sv
// Arbitrates two pixel-write requesters onto the LED panel write port (one write per cycle).
// Define LEDPANEL_WR_ARB_FILL_EN to add the whole-panel fill engine and its fill_* ports.
module ledpanel_wr_arb
    import ledpanel_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic             CLK12MHZ,
    input  logic             resetn,
    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic [X_W-1:0]   m0_x,
    input  logic [Y_W-1:0]   m0_y,
    input  logic [RGB_W-1:0] m0_rgb,
    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic [X_W-1:0]   m1_x,
    input  logic [Y_W-1:0]   m1_y,
    input  logic [RGB_W-1:0] m1_rgb,
`ifdef LEDPANEL_WR_ARB_FILL_EN
    input  logic             fill_start,
    input  logic [RGB_W-1:0] fill_rgb,
    output logic             fill_busy,
`endif
    output logic             wr_enable,
    output logic [X_W-1:0]   wr_addr_x,
    output logic [Y_W-1:0]   wr_addr_y,
    output logic [RGB_W-1:0] wr_rgb_data
);

    logic             gnt0, gnt1, arb_en;
    logic             fill_wr, xfer;
    logic [X_W-1:0]   fill_x, x_d;
    logic [Y_W-1:0]   fill_y, y_d;
    logic [RGB_W-1:0] fill_col, rgb_d;

`ifdef LEDPANEL_WR_ARB_FILL_EN
    fill_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RGB_W-1:0] colour_q, colour_d;

    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d  = FILL;
                    cnt_d    = '0;
                    colour_d = fill_rgb;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PIX_COUNT - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must silence the fill combinationally, before the state register clears.
    always_comb begin
        fill_busy = resetn & (state_q == FILL);
        fill_wr   = fill_busy;
        arb_en    = resetn & (state_q == IDLE);
        fill_x    = cnt_q[X_W-1:0];
        fill_y    = cnt_q[CNT_W-1:X_W];
        fill_col  = colour_q;
    end
`else
    always_comb begin
        fill_wr  = 1'b0;
        arb_en   = resetn;
        fill_x   = '0;
        fill_y   = '0;
        fill_col = '0;
    end
`endif

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .CLK12MHZ (CLK12MHZ),
        .resetn   (resetn),
        .en       (arb_en),
        .req0     (m0_valid),
        .req1     (m1_valid),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    always_comb begin
        m0_ready = gnt0;
        m1_ready = gnt1;
        xfer     = fill_wr | gnt0 | gnt1;
        x_d      = wr_addr_x;
        y_d      = wr_addr_y;
        rgb_d    = wr_rgb_data;
        if (fill_wr) begin
            x_d   = fill_x;
            y_d   = fill_y;
            rgb_d = fill_col;
        end else if (gnt0) begin
            x_d   = m0_x;
            y_d   = m0_y;
            rgb_d = m0_rgb;
        end else if (gnt1) begin
            x_d   = m1_x;
            y_d   = m1_y;
            rgb_d = m1_rgb;
        end
    end

    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            wr_enable   <= 1'b0;
            wr_addr_x   <= '0;
            wr_addr_y   <= '0;
            wr_rgb_data <= '0;
        end else begin
            wr_enable   <= xfer;
            wr_addr_x   <= x_d;
            wr_addr_y   <= y_d;
            wr_rgb_data <= rgb_d;
        end
    end

endmodule

// File: doc/ledpanel_wr_arb.md
LEDPANEL_WR_ARB -- requirements
Module: ledpanel_wr_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning: 1 selects round-robin arbitration; 0 selects fixed priority with m0 highest.
REQ-002 SHALL have port CLK12MHZ  in  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn  in  1  synchronous, active-low reset on clock CLK12MHZ.
REQ-004 SHALL have ports m0_valid in 1, m0_ready out 1, m0_x in 5, m0_y in 5, m0_rgb in 24, forming the CPU write requester.
REQ-005 SHALL have ports m1_valid in 1, m1_ready out 1, m1_x in 5, m1_y in 5, m1_rgb in 24, forming the second write requester.
REQ-006 SHALL have ports fill_start in 1, fill_rgb in 24, fill_busy out 1; these exist only with the fill feature compiled in.
REQ-007 SHALL have ports wr_enable out 1, wr_addr_x out 5, wr_addr_y out 5, wr_rgb_data out 24, which drive the LED panel write port.

Function
REQ-008 SHALL make m*_ready combinational (the grant); a transfer occurs on any cycle where valid and ready are both high.
REQ-009 SHALL grant at most one requester per cycle.
REQ-010 SHALL register the granted x/y/rgb onto wr_addr_x, wr_addr_y and wr_rgb_data, and pulse wr_enable for one cycle in the cycle after the transfer (latency 1).
REQ-011 SHALL hold wr_addr_x, wr_addr_y and wr_rgb_data at their last values whenever wr_enable is 0.
REQ-012 RR_EN=1: when both requesters are valid, SHALL grant the one not granted most recently; the last-grant pointer updates only on a transfer; the pointer resets to m1, so m0 wins the first tie.
REQ-013 RR_EN=0: SHALL grant m0 whenever m0_valid is high; m1 is granted only when m0_valid is low.
REQ-014 A single valid requester SHALL be granted in the same cycle, giving sustained throughput of 1 write per cycle.
REQ-015 Requesters SHALL hold x/y/rgb stable while valid is high and not ready; the block does not latch data before the transfer.
REQ-016 Fill state machine SHALL have two states, IDLE and FILL; fill_start high in IDLE latches fill_rgb, clears a 10-bit pixel counter and enters FILL on the next edge.
REQ-017 In FILL, SHALL issue one write per cycle with x = counter[4:0], y = counter[9:5] and rgb = the latched colour, then increment the counter; after the write with counter 1023 the counter wraps to 0 and the state returns to IDLE (exactly 1024 writes).
REQ-018 fill_busy SHALL be high exactly while the state is FILL.
REQ-019 m0_ready and m1_ready SHALL be 0 throughout FILL.
REQ-020 fill_start SHALL be ignored while in FILL.
REQ-021 If fill_start and a requester valid coincide in IDLE, the requester SHALL be granted in that same cycle and FILL begins on the next cycle.

Reset
REQ-022 With resetn low, on the clock edge: wr_enable=0, wr_addr_x=0, wr_addr_y=0, wr_rgb_data=0, fill state=IDLE, counter=0, last-grant=m1.
REQ-023 While resetn is low, m0_ready and m1_ready SHALL be 0 and fill_busy SHALL be 0.
REQ-024 Reset asserted mid-fill SHALL abort the fill with no further writes; the fill does not resume after reset releases.

Configuration
REQ-025 Macro LEDPANEL_WR_ARB_FILL_EN defined: the fill engine, its ports and REQ-016..021 are present.
REQ-026 Macro LEDPANEL_WR_ARB_FILL_EN undefined: the fill engine and the fill_start, fill_rgb and fill_busy ports are absent; the block is a pure two-requester arbiter.

Structure
REQ-027 Shared package ledpanel_pkg SHALL hold: X_W=5, Y_W=5, RGB_W=24, PIX_COUNT=1024, and the fill state enum {IDLE, FILL}.
REQ-028 Sub-module rr_arb2 SHALL implement the two-input grant logic and last-grant pointer, parameterised by RR_EN; everything else stays in ledpanel_wr_arb.

Verification
REQ-029 m0 only: m0_valid=1, x=3, y=7, rgb=0xFF0000 -> m0_ready=1 same cycle; next cycle wr_enable=1 with x=3, y=7, rgb=0xFF0000.
REQ-030 RR_EN=1, both requesters valid for 4 cycles -> grants m0, m1, m0, m1; 4 wr_enable pulses.
REQ-031 RR_EN=0, both requesters valid for 4 cycles -> m0 granted all 4 cycles; m1_ready stays 0.
REQ-032 fill_start with fill_rgb=0x00FF00 -> 1024 consecutive wr_enable pulses, addresses (0,0)..(31,31) x-fastest; fill_busy high 1024 cycles; m*_ready=0 throughout; second fill_start mid-fill has no effect.
REQ-033 resetn low at pixel 500 of a fill -> the next edge gives wr_enable=0, fill_busy=0 and outputs zeroed; no writes after reset releases.
